// File: rtl/iterative_alu_pkg.sv
// Shared ALU definitions: ALUOperation codes used by the ALU control decoder
// and by the execution units.
package iterative_alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_NOR  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_MULT = 4'b0111;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL);
    endfunction

endpackage

// File: rtl/iterative_alu_shift_mult.sv
// Iterative shift / shift-add multiply datapath with its iteration counter.
// lo_next/hi_next present the value after the current step so the final step can be captured directly.
module iterative_shift_mult #(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             mult_op,
    input  logic             left,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic [4:0]       shamt,
    output logic             last,
    output logic [NBITS-1:0] lo_next,
    output logic [NBITS-1:0] hi_next
);
    localparam int CW = $clog2(NBITS + 1);

    logic [NBITS-1:0] hi, lo, mcand;
    logic [CW-1:0]    count;
    logic             is_mult, is_left;
    logic [NBITS-1:0] addend;
    logic [NBITS:0]   sum;

    // Product register {hi, lo} shifts right; lo initially holds the multiplier.
    always_comb begin
        addend  = lo[0] ? mcand : '0;
        sum     = {1'b0, hi} + {1'b0, addend};
        hi_next = hi;
        lo_next = lo;
        if (is_mult) begin
            hi_next = sum[NBITS:1];
            lo_next = {sum[0], lo[NBITS-1:1]};
        end else if (is_left) begin
            lo_next = {lo[NBITS-2:0], 1'b0};
        end else begin
            lo_next = {1'b0, lo[NBITS-1:1]};
        end
    end

    assign last = (count == CW'(1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi      <= '0;
            lo      <= '0;
            mcand   <= '0;
            count   <= '0;
            is_mult <= 1'b0;
            is_left <= 1'b0;
        end else if (load) begin
            hi      <= '0;
            lo      <= b;
            mcand   <= a;
            count   <= mult_op ? CW'(NBITS) : CW'(shamt);
            is_mult <= mult_op;
            is_left <= left;
        end else if (step) begin
            hi    <= hi_next;
            lo    <= lo_next;
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/iterative_alu.sv
// Multi-cycle ALU with start/done handshake: single-cycle logic/arithmetic ops,
// iterative shifts (one bit per cycle) and a shift-add unsigned multiply.
module iterative_alu
    import iterative_alu_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUOperation,
    input  logic [NBITS-1:0] A,
    input  logic [NBITS-1:0] B,
    input  logic [4:0]       shamt,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] ALUResult,
    output logic [NBITS-1:0] ALUResultHi,
    output logic             Zero,
    output logic             invalid_op
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic             accept, multi, last;
    logic [NBITS-1:0] lo_next, hi_next, quick_result;
    logic             quick_invalid;

    assign accept = (state == IDLE) && start;
    assign multi  = (ALUOperation == OP_MULT) || (is_shift_op(ALUOperation) && (shamt != 5'd0));
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = multi ? RUN : DONE;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ops finishing in one cycle, including shifts by zero which pass B through.
    always_comb begin
        quick_result  = '0;
        quick_invalid = 1'b0;
        case (ALUOperation)
            OP_AND:          quick_result = A & B;
            OP_OR:           quick_result = A | B;
            OP_NOR:          quick_result = ~(A | B);
            OP_ADD:          quick_result = A + B;
            OP_SUB:          quick_result = A - B;
            OP_SLL, OP_SRL:  quick_result = B;
            default:         quick_invalid = 1'b1;
        endcase
    end

    iterative_shift_mult #(.NBITS(NBITS)) u_shift_mult (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .step    (state == RUN),
        .mult_op (ALUOperation == OP_MULT),
        .left    (ALUOperation == OP_SLL),
        .a       (A),
        .b       (B),
        .shamt   (shamt),
        .last    (last),
        .lo_next (lo_next),
        .hi_next (hi_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            ALUResult   <= '0;
            ALUResultHi <= '0;
            Zero        <= 1'b1;
            invalid_op  <= 1'b0;
        end else if (accept && !multi) begin
            ALUResult   <= quick_result;
            ALUResultHi <= '0;
            Zero        <= (quick_result == '0);
            invalid_op  <= quick_invalid;
        end else if ((state == RUN) && last) begin
            ALUResult   <= lo_next;
            ALUResultHi <= hi_next;
            Zero        <= (lo_next == '0);
            invalid_op  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iterative_alu.sv
// Directed self-checking bench for iterative_alu.
module tb_iterative_alu;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  ALUOperation;
    logic [31:0] A, B;
    logic [4:0]  shamt;
    logic        busy, done, Zero, invalid_op;
    logic [31:0] ALUResult, ALUResultHi;

    int checks = 0;
    int errors = 0;

    iterative_alu #(.NBITS(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ALUOperation (ALUOperation),
        .A            (A),
        .B            (B),
        .shamt        (shamt),
        .busy         (busy),
        .done         (done),
        .ALUResult    (ALUResult),
        .ALUResultHi  (ALUResultHi),
        .Zero         (Zero),
        .invalid_op   (invalid_op)
    );

    always #5 clk = ~clk;

    // Returns the cycle (acceptance edge = 0) in which done is first seen; 99 on timeout.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output int cyc);
        @(negedge clk);
        start = 1'b1; ALUOperation = op; A = a; B = b; shamt = sh;
        @(negedge clk);
        start = 1'b0;
        A = ~a; B = ~b; shamt = ~sh;
        cyc = 1;
        while (!done && cyc < 99) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; ALUOperation = '0; A = '0; B = '0; shamt = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (ALUResult !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", ALUResult); end
        checks++; if (ALUResultHi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", ALUResultHi); end
        checks++; if (Zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %0b want 1", Zero); end
        checks++; if (invalid_op !== 1'b0) begin errors++; $display("FAIL reset_invalid got %0b want 0", invalid_op); end
        reset = 1'b1;
    endtask

    task automatic test_logic();
        int c;
        do_op(4'b0000, 32'hF0F000FF, 32'h0FF00F0F, 5'd0, c);
        checks++; if (c != 1) begin errors++; $display("FAIL and_cycle got %0d want 1", c); end
        checks++; if (ALUResult !== 32'h00F0000F) begin errors++; $display("FAIL and_result got %h want 00f0000f", ALUResult); end
        checks++; if (Zero !== 1'b0) begin errors++; $display("FAIL and_zero got %0b want 0", Zero); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL and_busy_after got busy=%0b done=%0b want 0 0", busy, done); end
        do_op(4'b0001, 32'hF0F000FF, 32'h0FF00F0F, 5'd0, c);
        checks++; if (ALUResult !== 32'hFFF00FFF) begin errors++; $display("FAIL or_result got %h want fff00fff", ALUResult); end
        do_op(4'b0010, 32'hF0F000FF, 32'h0FF00F0F, 5'd0, c);
        checks++; if (ALUResult !== 32'h000FF000) begin errors++; $display("FAIL nor_result got %h want 000ff000", ALUResult); end
    endtask

    task automatic test_arith();
        int c;
        do_op(4'b0011, 32'hFFFFFFFF, 32'h00000001, 5'd0, c);
        checks++; if (c != 1) begin errors++; $display("FAIL add_cycle got %0d want 1", c); end
        checks++; if (ALUResult !== 32'h0) begin errors++; $display("FAIL add_result got %h want 0", ALUResult); end
        checks++; if (Zero !== 1'b1) begin errors++; $display("FAIL add_zero got %0b want 1", Zero); end
        do_op(4'b0100, 32'h0, 32'h1, 5'd0, c);
        checks++; if (ALUResult !== 32'hFFFFFFFF) begin errors++; $display("FAIL sub_result got %h want ffffffff", ALUResult); end
        checks++; if (Zero !== 1'b0 || ALUResultHi !== 32'h0) begin errors++; $display("FAIL sub_flags got zero=%0b hi=%h want 0 0", Zero, ALUResultHi); end
    endtask

    task automatic test_shift();
        int c;
        do_op(4'b0101, 32'h0, 32'h00000001, 5'd31, c);
        checks++; if (c != 32) begin errors++; $display("FAIL sll31_cycle got %0d want 32", c); end
        checks++; if (ALUResult !== 32'h80000000) begin errors++; $display("FAIL sll31_result got %h want 80000000", ALUResult); end
        do_op(4'b0110, 32'h0, 32'h80000000, 5'd4, c);
        checks++; if (c != 5) begin errors++; $display("FAIL srl4_cycle got %0d want 5", c); end
        checks++; if (ALUResult !== 32'h08000000) begin errors++; $display("FAIL srl4_result got %h want 08000000", ALUResult); end
        do_op(4'b0101, 32'h0, 32'h12345678, 5'd0, c);
        checks++; if (c != 1) begin errors++; $display("FAIL sll0_cycle got %0d want 1", c); end
        checks++; if (ALUResult !== 32'h12345678) begin errors++; $display("FAIL sll0_result got %h want 12345678", ALUResult); end
    endtask

    task automatic test_mult();
        int c;
        @(negedge clk);
        start = 1'b1; ALUOperation = 4'b0111; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; shamt = 5'd0;
        @(negedge clk);
        start = 1'b0; A = 32'h0; B = 32'h0;
        c = 1;
        while (!done && c < 99) begin
            @(negedge clk);
            c++;
            if (c == 10) begin
                start = 1'b1; ALUOperation = 4'b0011; A = 32'h1; B = 32'h1;
            end else begin
                start = 1'b0;
            end
        end
        checks++; if (c != 33) begin errors++; $display("FAIL mult_cycle got %0d want 33", c); end
        checks++; if (ALUResultHi !== 32'hFFFFFFFE) begin errors++; $display("FAIL mult_hi got %h want fffffffe", ALUResultHi); end
        checks++; if (ALUResult !== 32'h00000001) begin errors++; $display("FAIL mult_lo got %h want 00000001", ALUResult); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mult_no_queue got busy=%0b done=%0b want 0 0", busy, done); end
        do_op(4'b0111, 32'h00010000, 32'h00010000, 5'd0, c);
        checks++; if (ALUResultHi !== 32'h1 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
            errors++; $display("FAIL mult_2e32 got hi=%h lo=%h zero=%0b want 1 0 1", ALUResultHi, ALUResult, Zero); end
    endtask

    task automatic test_invalid();
        int c;
        do_op(4'b1001, 32'h5, 32'h7, 5'd0, c);
        checks++; if (c != 1) begin errors++; $display("FAIL inv_cycle got %0d want 1", c); end
        checks++; if (invalid_op !== 1'b1 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
            errors++; $display("FAIL inv_outputs got inv=%0b res=%h zero=%0b want 1 0 1", invalid_op, ALUResult, Zero); end
        do_op(4'b0011, 32'h2, 32'h3, 5'd0, c);
        checks++; if (invalid_op !== 1'b0 || ALUResult !== 32'h5) begin
            errors++; $display("FAIL inv_clear got inv=%0b res=%h want 0 5", invalid_op, ALUResult); end
        do_op(4'b1111, 32'h5, 32'h7, 5'd0, c);
        checks++; if (invalid_op !== 1'b1) begin errors++; $display("FAIL inv_1111 got %0b want 1", invalid_op); end
        do_op(4'b0011, 32'h2, 32'h3, 5'd0, c);
    endtask

    task automatic test_reset_mid();
        int c;
        bit saw_done = 0;
        @(negedge clk);
        start = 1'b1; ALUOperation = 4'b0111; A = 32'h3; B = 32'h5;
        @(negedge clk);
        start = 1'b0;
        for (int i = 2; i <= 10; i++) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (saw_done || done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl got saw_done=%0b done=%0b busy=%0b want 0 0 0", saw_done, done, busy); end
        checks++; if (ALUResult !== 32'h0 || ALUResultHi !== 32'h0 || Zero !== 1'b1 || invalid_op !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got res=%h hi=%h zero=%0b inv=%0b want 0 0 1 0", ALUResult, ALUResultHi, Zero, invalid_op); end
        reset = 1'b1;
        do_op(4'b0011, 32'h7, 32'h8, 5'd0, c);
        checks++; if (c != 1 || ALUResult !== 32'hF) begin errors++; $display("FAIL postrst_add got cyc=%0d res=%h want 1 f", c, ALUResult); end
        // reset together with start
        @(negedge clk);
        reset = 1'b0; start = 1'b1; ALUOperation = 4'b0011; A = 32'h1; B = 32'h1;
        @(negedge clk);
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0 || ALUResult !== 32'h0) begin
            errors++; $display("FAIL rst_start got busy=%0b done=%0b res=%h want 0 0 0", busy, done, ALUResult); end
    endtask

    task automatic test_back_to_back();
        int c;
        do_op(4'b0011, 32'h1, 32'h1, 5'd0, c);
        start = 1'b1; ALUOperation = 4'b0001; A = 32'hA0; B = 32'h0B;
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || ALUResult !== 32'h2) begin
            errors++; $display("FAIL b2b_ignore got done=%0b busy=%0b res=%h want 0 0 2", done, busy, ALUResult); end
        @(negedge clk);
        start = 1'b0;
        checks++; if (done !== 1'b1 || ALUResult !== 32'hAB) begin
            errors++; $display("FAIL b2b_accept got done=%0b res=%h want 1 ab", done, ALUResult); end
    endtask

    initial begin
        test_reset();
        test_logic();
        test_arith();
        test_shift();
        test_mult();
        test_invalid();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
